// File: rtl/signmag_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | signmag_alu_seq : sequential sign-magnitude add/sub/shift-add multiply   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module signmag_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     A_mag,
   input  logic [WIDTH-1:0]     B_mag,
   input  logic                 sign_A,
   input  logic                 sign_B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result_mag,
   output logic                 result_sign,
   output logic                 overflow,
   output logic                 error
);

   localparam int c_CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ADDSUB = 2'd1,
      S_MUL    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic                 sa_q, sa_d, sb_q, sb_d;
   logic [1:0]           op_q, op_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [c_CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   res_mag_q, res_mag_d;
   logic                 res_sign_q, res_sign_d;
   logic                 ovf_q, ovf_d;
   logic                 err_q, err_d;

   logic                 w_accept;
   logic                 w_eop_sub;
   logic [WIDTH:0]       w_as_mag;
   logic                 w_as_sign;
   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_prod;

   always_comb begin
      w_accept  = start && (state_q == S_IDLE || state_q == S_DONE);
      w_eop_sub = op_q[0] ^ sa_q ^ sb_q;
      if (!w_eop_sub) begin
         w_as_mag  = {1'b0, a_q} + {1'b0, b_q};
         w_as_sign = sa_q;
      end else if (a_q >= b_q) begin
         w_as_mag  = {1'b0, a_q} - {1'b0, b_q};
         w_as_sign = sa_q;
      end else begin
         w_as_mag  = {1'b0, b_q} - {1'b0, a_q};
         w_as_sign = sb_q ^ op_q[0];
      end
      // Upper half accumulates the multiplicand; the carry shifts back in on the right shift.
      w_mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
      w_mul_prod = {w_mul_sum, prod_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      op_d       = op_q;
      prod_d     = prod_q;
      cnt_d      = cnt_q;
      res_mag_d  = res_mag_q;
      res_sign_d = res_sign_q;
      ovf_d      = ovf_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               a_d     = A_mag;
               b_d     = B_mag;
               sa_d    = sign_A;
               sb_d    = sign_B;
               op_d    = op;
               prod_d  = {{WIDTH{1'b0}}, B_mag};
               cnt_d   = '0;
               state_d = (op == 2'b10) ? S_MUL : S_ADDSUB;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDSUB: begin
            state_d = S_DONE;
            if (op_q == 2'b11) begin
               res_mag_d  = '0;
               res_sign_d = 1'b0;
               ovf_d      = 1'b0;
               err_d      = 1'b1;
            end else begin
               res_mag_d  = {{(WIDTH-1){1'b0}}, w_as_mag};
               res_sign_d = w_as_sign & (|w_as_mag);
               ovf_d      = w_as_mag[WIDTH];
               err_d      = 1'b0;
            end
         end
         S_MUL: begin
            prod_d = w_mul_prod;
            cnt_d  = cnt_q + c_CNT_W'(1);
            if (cnt_q == c_CNT_W'(WIDTH - 1)) begin
               state_d    = S_DONE;
               res_mag_d  = w_mul_prod;
               res_sign_d = (sa_q ^ sb_q) & (|w_mul_prod);
               ovf_d      = |w_mul_prod[2*WIDTH-1:WIDTH];
               err_d      = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         op_q       <= '0;
         prod_q     <= '0;
         cnt_q      <= '0;
         res_mag_q  <= '0;
         res_sign_q <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         op_q       <= op_d;
         prod_q     <= prod_d;
         cnt_q      <= cnt_d;
         res_mag_q  <= res_mag_d;
         res_sign_q <= res_sign_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
      end
   end

   assign busy        = (state_q == S_ADDSUB) || (state_q == S_MUL);
   assign done        = (state_q == S_DONE);
   assign result_mag  = res_mag_q;
   assign result_sign = res_sign_q;
   assign overflow    = ovf_q;
   assign error       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_signmag_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_signmag_alu_seq : scoreboard bench for signmag_alu_seq (WIDTH=8)      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_signmag_alu_seq;

   localparam int W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        op;
   logic [W-1:0]      A_mag, B_mag;
   logic              sign_A, sign_B;
   logic              busy, done;
   logic [2*W-1:0]    result_mag;
   logic              result_sign, overflow, error;

   signmag_alu_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .A_mag       (A_mag),
      .B_mag       (B_mag),
      .sign_A      (sign_A),
      .sign_B      (sign_B),
      .busy        (busy),
      .done        (done),
      .result_mag  (result_mag),
      .result_sign (result_sign),
      .overflow    (overflow),
      .error       (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2*W-1:0] mag;
      logic           sign;
      logic           ovf;
      logic           err;
      int             at_cyc;
      int             busy_cycles;
   } exp_t;

   exp_t q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per done pulse and checks values, timing and busy span.
   initial begin
      exp_t e;
      logic prev_done = 1'b0;
      int   busy_run  = 0;
      forever begin
         @(negedge clk);
         if (done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("result_mag",  {16'd0, result_mag}, {16'd0, e.mag});
               check("result_sign", {31'd0, result_sign}, {31'd0, e.sign});
               check("overflow",    {31'd0, overflow}, {31'd0, e.ovf});
               check("error",       {31'd0, error}, {31'd0, e.err});
               check("done_cycle",  cyc, e.at_cyc);
               check("busy_cycles", busy_run, e.busy_cycles);
            end
            busy_run = 0;
         end else if (busy) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
         prev_done = done;
      end
   end

   task automatic push_exp(input logic [15:0] m, input logic s, input logic o, input logic er,
                           input int at, input int bc);
      exp_t e;
      e.mag = m; e.sign = s; e.ovf = o; e.err = er; e.at_cyc = at; e.busy_cycles = bc;
      q.push_back(e);
   endtask

   task automatic drive(input logic [1:0] o, input logic sa, input logic [7:0] am,
                        input logic sb, input logic [7:0] bm);
      op = o; sign_A = sa; A_mag = am; sign_B = sb; B_mag = bm; start = 1'b1;
   endtask

   // Issues one op from IDLE/DONE and queues its hand-computed result.
   task automatic issue(input logic [1:0] o, input logic sa, input logic [7:0] am,
                        input logic sb, input logic [7:0] bm,
                        input logic [15:0] em, input logic es, input logic eo, input logic ee);
      #1;
      drive(o, sa, am, sb, bm);
      @(posedge clk); #1;
      start = 1'b0;
      push_exp(em, es, eo, ee, cyc + ((o == 2'b10) ? W : 1), (o == 2'b10) ? W : 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      check("done_timeout", q.size(), 0);
      q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},  {31'd0, busy}, 32'd0);
      check({tag, "_done"},  {31'd0, done}, 32'd0);
      check({tag, "_mag"},   {16'd0, result_mag}, 32'd0);
      check({tag, "_sign"},  {31'd0, result_sign}, 32'd0);
      check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
      check({tag, "_err"},   {31'd0, error}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00;
      A_mag = '0; B_mag = '0; sign_A = 1'b0; sign_B = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk);

      // +5 add -9 = -4
      issue(2'b00, 1'b0, 8'd5, 1'b1, 8'd9, 16'd4, 1'b1, 1'b0, 1'b0);
      wait_done();
      // -7 sub -7 = 0, no negative zero
      issue(2'b01, 1'b1, 8'd7, 1'b1, 8'd7, 16'd0, 1'b0, 1'b0, 1'b0);
      wait_done();
      // +3 sub +10 = -7
      issue(2'b01, 1'b0, 8'd3, 1'b0, 8'd10, 16'd7, 1'b1, 1'b0, 1'b0);
      wait_done();
      // +200 add +100 = 300, overflow
      issue(2'b00, 1'b0, 8'd200, 1'b0, 8'd100, 16'd300, 1'b0, 1'b1, 1'b0);
      wait_done();
      // -200 sub +100 = -300, overflow
      issue(2'b01, 1'b1, 8'd200, 1'b0, 8'd100, 16'd300, 1'b1, 1'b1, 1'b0);
      wait_done();

      // -12 mul +13 = -156, with a stray start at edge k+3 that must be ignored
      issue(2'b10, 1'b1, 8'd12, 1'b0, 8'd13, 16'd156, 1'b1, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      drive(2'b00, 1'b0, 8'd1, 1'b0, 8'd1);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();

      // 255 mul 255 = 65025, overflow
      issue(2'b10, 1'b0, 8'd255, 1'b0, 8'd255, 16'd65025, 1'b0, 1'b1, 1'b0);
      wait_done();

      // Same multiply aborted by reset at the fourth iteration edge
      #1;
      drive(2'b10, 1'b0, 8'd255, 1'b0, 8'd255);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check_outputs_zero("abort");
      rst = 1'b0;
      repeat (12) @(posedge clk);
      check("abort_idle_busy", {31'd0, busy}, 32'd0);

      // 2 mul 3 = 6 after the abort
      issue(2'b10, 1'b0, 8'd2, 1'b0, 8'd3, 16'd6, 1'b0, 1'b0, 1'b0);
      wait_done();

      // Illegal op, then +1 add +1 launched from DONE with start held high
      #1;
      drive(2'b11, 1'b1, 8'd5, 1'b0, 8'd9);
      @(posedge clk); #1;
      push_exp(16'd0, 1'b0, 1'b0, 1'b1, cyc + 1, 1);
      push_exp(16'd2, 1'b0, 1'b0, 1'b0, cyc + 3, 1);
      drive(2'b00, 1'b0, 8'd1, 1'b0, 8'd1);
      @(posedge clk); @(posedge clk); #1;
      start = 1'b0;
      wait_done();

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
